// File: rtl/updown_count_sequencer.sv
// rtl/updown_count_sequencer.sv - command-driven up/down counter with step budget, hold and done/wrap pulses
module updown_count_sequencer #(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_load,
  input  logic [WIDTH-1:0]   cmd_load_val,
  input  logic               hold,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   Q_not,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ALL_ONES = '1;
  localparam logic [WIDTH-1:0]   ZERO     = '0;
  localparam logic [STEPS_W-1:0] ONE_STEP = STEPS_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   q_r;
  logic               dir_r;
  logic [STEPS_W-1:0] remaining;
  logic               wrap_r;
  logic               accept;
  logic               step;

  // State register; reset abandons any command in flight without a done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore outputs; cmd_ready depends only on state and rst
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = ~rst;
        accept    = cmd_valid;
        if (cmd_valid) begin
          state_nxt = (cmd_steps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = ~hold;
        if (~hold && (remaining == ONE_STEP)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Count datapath: preload and latch the command at accept, one step per unheld RUN edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r       <= ZERO;
      dir_r     <= 1'b0;
      remaining <= '0;
      wrap_r    <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (accept) begin
        if (cmd_load) begin
          q_r <= cmd_load_val;
        end
        dir_r     <= cmd_dir;
        remaining <= cmd_steps;
      end else if (step) begin
        remaining <= remaining - ONE_STEP;
        if (dir_r) begin
          q_r    <= q_r + 1'b1;
          wrap_r <= (q_r == ALL_ONES);
        end else begin
          q_r    <= q_r - 1'b1;
          wrap_r <= (q_r == ZERO);
        end
      end
    end
  end

  assign Q     = q_r;
  assign Q_not = ~q_r;
  assign wrap  = wrap_r;

endmodule

// File: tb/tb_updown_count_sequencer.sv
// tb/tb_updown_count_sequencer.sv - scoreboard bench for updown_count_sequencer
module tb_updown_count_sequencer;
  localparam int WIDTH   = 4;
  localparam int STEPS_W = 8;
  localparam int MOD     = 1 << WIDTH;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_dir = 1'b0;
  logic [STEPS_W-1:0] cmd_steps = '0;
  logic               cmd_load = 1'b0;
  logic [WIDTH-1:0]   cmd_load_val = '0;
  logic               hold = 1'b0;
  logic [WIDTH-1:0]   Q;
  logic [WIDTH-1:0]   Q_not;
  logic               busy;
  logic               done;
  logic               wrap;

  updown_count_sequencer #(.WIDTH(WIDTH), .STEPS_W(STEPS_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_load(cmd_load),
    .cmd_load_val(cmd_load_val), .hold(hold), .Q(Q), .Q_not(Q_not),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct { int q; bit wrp; } q_ev_t;
  typedef struct { int edge_n; int q; } done_ev_t;

  q_ev_t    q_exp[$];
  done_ev_t done_exp[$];

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  bit mon_on = 0;
  int mq = 0;
  int exp_cur = 0;
  logic [WIDTH-1:0] prev_q = '0;
  bit mon_ew;
  q_ev_t    mon_qe;
  done_ev_t mon_de;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event at edge %0d (Q=%0d)", name, edge_cnt, Q);
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: every change of Q consumes one expected value; every done pulse consumes one completion
  always @(negedge clk) begin
    if (mon_on) begin
      mon_ew = 1'b0;
      if (Q !== prev_q) begin
        if (q_exp.size() == 0) begin
          fail_evt("q_change");
        end else begin
          mon_qe  = q_exp.pop_front();
          exp_cur = mon_qe.q;
          mon_ew  = mon_qe.wrp;
        end
      end
      check("q", int'(Q), exp_cur);
      check("q_not", int'(Q_not), (MOD - 1) - exp_cur);
      check("wrap", int'(wrap), int'(mon_ew));
      if (done) begin
        if (done_exp.size() == 0) begin
          fail_evt("done");
        end else begin
          mon_de = done_exp.pop_front();
          check("done_edge", edge_cnt, mon_de.edge_n);
          check("done_q", int'(Q), mon_de.q);
        end
      end
    end
    prev_q <= Q;
  end

  task automatic garbage_cmd();
    cmd_valid    = 1'($urandom_range(0, 1));
    cmd_dir      = 1'($urandom_range(0, 1));
    cmd_steps    = STEPS_W'($urandom_range(0, 255));
    cmd_load     = 1'($urandom_range(0, 1));
    cmd_load_val = WIDTH'($urandom_range(0, MOD - 1));
  endtask

  task automatic model_step(input bit d, input int rem_after);
    q_ev_t e;
    done_ev_t de;
    int v;
    v     = mq + (d ? 1 : -1);
    e.wrp = (v < 0) || (v >= MOD);
    mq    = (v + MOD) % MOD;
    e.q   = mq;
    q_exp.push_back(e);
    if (rem_after == 0) begin
      de.edge_n = edge_cnt + 1;
      de.q      = mq;
      done_exp.push_back(de);
    end
  endtask

  task automatic reset_mid();
    mon_on = 0;
    #2 rst = 1'b1;
    #1;
    check("rst_q", int'(Q), 0);
    check("rst_q_not", int'(Q_not), MOD - 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 0);
    q_exp.delete();
    done_exp.delete();
    mq = 0;
    exp_cur = 0;
    cmd_valid = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1;
    check("ready_after_rst", int'(cmd_ready), 1);
    check("busy_after_rst", int'(busy), 0);
  endtask

  // Issue one command from IDLE (called at a negedge) and follow it to completion
  task automatic run_cmd(input bit d, input int n, input bit ld, input int lv,
                         input int hold_pct, input int abort_q);
    q_ev_t e;
    done_ev_t de;
    int rem;
    check("ready_idle", int'(cmd_ready), 1);
    check("busy_idle", int'(busy), 0);
    cmd_valid    = 1'b1;
    cmd_dir      = d;
    cmd_steps    = STEPS_W'(n);
    cmd_load     = ld;
    cmd_load_val = WIDTH'(lv);
    hold         = 1'($urandom_range(0, 1));
    if (ld && lv != mq) begin
      e.q = lv;
      e.wrp = 1'b0;
      q_exp.push_back(e);
    end
    if (ld) mq = lv;
    rem = n;
    if (rem == 0) begin
      de.edge_n = edge_cnt + 1;
      de.q      = mq;
      done_exp.push_back(de);
    end
    @(negedge clk);
    while (rem > 0) begin
      check("ready_run", int'(cmd_ready), 0);
      check("busy_run", int'(busy), 1);
      if (abort_q >= 0 && mq == abort_q) begin
        reset_mid();
        return;
      end
      garbage_cmd();
      hold = ($urandom_range(0, 99) < hold_pct);
      if (!hold) begin
        rem--;
        model_step(d, rem);
      end
      @(negedge clk);
    end
    check("ready_done", int'(cmd_ready), 0);
    check("busy_done", int'(busy), 1);
    garbage_cmd();
    hold = 1'($urandom_range(0, 1));
    @(negedge clk);
    cmd_valid = 1'b0;
    hold      = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got edge %0d expected completion", edge_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    check("init_q", int'(Q), 0);
    check("init_q_not", int'(Q_not), MOD - 1);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_wrap", int'(wrap), 0);
    check("init_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    mon_on = 1;

    run_cmd(1'b1, 5, 1'b0, 0, 0, -1);
    check("up5_final", int'(Q), 5);
    run_cmd(1'b0, 4, 1'b1, 2, 0, -1);
    check("down_wrap_q_not", int'(Q_not), 1);
    run_cmd(1'b1, 3, 1'b1, 0, 50, -1);
    run_cmd(1'b0, 0, 1'b1, 9, 0, -1);
    @(negedge clk);
    check("zero_steps_q", int'(Q), 9);
    run_cmd(1'b1, 10, 1'b1, 0, 0, 3);
    run_cmd(1'b1, 255, 1'b1, 7, 0, -1);
    check("max_steps_q", int'(Q), 6);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cmd_valid    = 1'b0;
        cmd_load_val = WIDTH'($urandom_range(0, MOD - 1));
        hold         = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      hold = 1'b0;
      run_cmd(1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)), 30, -1);
    end

    repeat (3) @(negedge clk);
    check("q_exp_drained", q_exp.size(), 0);
    check("done_exp_drained", done_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
